// File: rtl/pipe_skid_stage_pkg.sv
// Constants shared by the pipeline stage registers: default payload widths,
// the bubble fill value and the occupancy encoding.
package pipe_skid_stage_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 16;
   localparam int OCC_W      = 2;

   // Every bit of a bubble's payload takes this value.
   localparam logic BUBBLE_BIT = 1'b0;

   function automatic logic [OCC_W-1:0] occ_count(input logic main_v, input logic skid_v);
      return {1'b0, main_v} + {1'b0, skid_v};
   endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register (valid + data + ctrl). Clear wins over load and
// zeroes the payload so an empty skid never carries stale control bits.
module pipe_skid_buf
   import pipe_skid_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              clear_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [CTRL_W-1:0] ctrl_o
);

   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [CTRL_W-1:0] ctrl_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (reset || clear_i) begin
         valid_q <= 1'b0;
         data_q  <= {DATA_W{BUBBLE_BIT}};
         ctrl_q  <= {CTRL_W{BUBBLE_BIT}};
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         ctrl_q  <= ctrl_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage register with stall and flush. Defining
// PIPE_SKID_EN adds a one-entry skid so in_ready is purely registered.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   input  logic              stall,
   input  logic              flush,
   output logic [OCC_W-1:0]  occupancy
);

   logic              main_valid_q, main_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
   logic [OCC_W-1:0]  occ_q,        occ_d;
   logic              accept, drain;

   assign accept = in_valid && in_ready && !flush;
   assign drain  = main_valid_q && out_ready && !stall;

`ifdef PIPE_SKID_EN
   logic              skid_valid, skid_valid_d;
   logic              skid_load, skid_move, skid_clear;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   assign in_ready   = !skid_valid;
   assign skid_move  = skid_valid && (drain || !main_valid_q);
   assign skid_load  = accept && main_valid_q && !drain;
   assign skid_clear = flush || skid_move;
   assign skid_valid_d = flush ? 1'b0 : (skid_load || (skid_valid && !skid_move));

   pipe_skid_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .Clk     (Clk),
      .reset   (reset),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (in_data),
      .ctrl_i  (in_ctrl),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .ctrl_o  (skid_ctrl)
   );

   always_comb begin
      // NOTE: defaults first so no path through this block infers a latch.
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      if (flush) begin
         main_valid_d = 1'b0;
         main_data_d  = {DATA_W{BUBBLE_BIT}};
         main_ctrl_d  = {CTRL_W{BUBBLE_BIT}};
      end else if (drain || !main_valid_q) begin
         if (skid_valid) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data;
            main_ctrl_d  = skid_ctrl;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
            main_ctrl_d  = in_ctrl;
         end else begin
            main_valid_d = 1'b0;
            main_data_d  = {DATA_W{BUBBLE_BIT}};
            main_ctrl_d  = {CTRL_W{BUBBLE_BIT}};
         end
      end
      occ_d = occ_count(main_valid_d, skid_valid_d);
   end
`else
   // Without the skid, a draining main register can take a new entry the same cycle.
   assign in_ready = !main_valid_q || (out_ready && !stall);

   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      if (flush || (drain && !accept)) begin
         main_valid_d = 1'b0;
         main_data_d  = {DATA_W{BUBBLE_BIT}};
         main_ctrl_d  = {CTRL_W{BUBBLE_BIT}};
      end else if (accept) begin
         main_valid_d = 1'b1;
         main_data_d  = in_data;
         main_ctrl_d  = in_ctrl;
      end
      occ_d = occ_count(main_valid_d, 1'b0);
   end
`endif

   // NOTE: payload registers are reset too, since out_data/out_ctrl must read zero for a bubble.
   always_ff @(posedge Clk) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= {DATA_W{BUBBLE_BIT}};
         main_ctrl_q  <= {CTRL_W{BUBBLE_BIT}};
         occ_q        <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_ctrl_q  <= main_ctrl_d;
         occ_q        <= occ_d;
      end
   end

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_ctrl  = main_ctrl_q;
   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Randomized bench for pipe_skid_stage against a queue model of the stage;
// follows PIPE_SKID_EN to pick the model's capacity and in_ready rule.
module tb_pipe_skid_stage;

`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_data = '0;
   logic [15:0] in_ctrl = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [31:0] out_data;
   logic [15:0] out_ctrl;
   logic        stall = 1'b0, flush = 1'b0;
   logic [1:0]  occupancy;

   always #5 Clk = ~Clk;

   pipe_skid_stage dut (
      .Clk       (Clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .stall     (stall),
      .flush     (flush),
      .occupancy (occupancy)
   );

   typedef struct {
      logic [31:0] d;
      logic [15:0] c;
   } ent_t;

   ent_t q[$];
   bit   model_known = 1'b0;
   int   n_total = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: drive at negedge, compare outputs against the model, then advance the model.
   task automatic cycle(input bit rst, input bit iv, input logic [31:0] d, input logic [15:0] c,
                        input bit ordy, input bit st, input bit fl);
      bit   exp_rdy, dr, ac;
      ent_t e;
      @(negedge Clk);
      reset = rst; in_valid = iv; in_data = d; in_ctrl = c;
      out_ready = ordy; stall = st; flush = fl;
      #1;
      exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || (ordy && !st));
      if (model_known) begin
         check("in_ready",  64'(in_ready),  64'(exp_rdy));
         check("out_valid", 64'(out_valid), 64'(q.size() > 0));
         check("out_data",  64'(out_data),  (q.size() > 0) ? 64'(q[0].d) : 64'd0);
         check("out_ctrl",  64'(out_ctrl),  (q.size() > 0) ? 64'(q[0].c) : 64'd0);
         check("occupancy", 64'(occupancy), 64'(q.size()));
      end
      if (rst) begin
         q.delete();
         model_known = 1'b1;
      end else if (fl) begin
         q.delete();
      end else begin
         dr = (q.size() > 0) && ordy && !st;
         ac = iv && exp_rdy;
         if (dr) void'(q.pop_front());
         if (ac) begin
            e.d = d;
            e.c = c;
            q.push_back(e);
         end
      end
   endtask

   task automatic idle(input bit ordy);
      cycle(1'b0, 1'b0, 32'h0, 16'h0, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      cycle(1'b1, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'hdead, 16'h1, 1'b1, 1'b1, 1'b1);
      idle(1'b0);

      // single entry, latency 1
      cycle(1'b0, 1'b1, 32'h1234, 16'h0003, 1'b1, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b1);

      // back-to-back stream
      for (int i = 1; i <= 4; i++)
         cycle(1'b0, 1'b1, 32'(i), 16'(i), 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      // stall with A, B arriving, then release
      cycle(1'b0, 1'b1, 32'haaaa, 16'h00a0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'hbbbb, 16'h00b0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'hcccc, 16'h00c0, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b0);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // flush while full with an incoming entry
      cycle(1'b0, 1'b1, 32'h1111, 16'h0011, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'h2222, 16'h0022, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b1, 32'h3333, 16'h0033, 1'b1, 1'b1, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // reset mid-transfer with stall
      cycle(1'b0, 1'b1, 32'h5555, 16'h0055, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h6666, 16'h0066, 1'b1, 1'b1, 1'b0);
      idle(1'b1);

      // hold then replace on drain
      cycle(1'b0, 1'b1, 32'h7777, 16'h0077, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h8888, 16'h0088, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h9999, 16'h0099, 1'b1, 1'b0, 1'b0);
      idle(1'b1);
      idle(1'b1);

      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom,
               16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 49) == 0);
      idle(1'b1);
      idle(1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
